// File: rtl/fp_reduce_pkg.sv
// fp_reduce_pkg: shared constants, state encoding and NaN test for recoded FP32 min/max reductions
package fp_reduce_pkg;
  localparam int REC_W = 33;
  localparam int FLAG_W = 5;
  localparam logic [REC_W-1:0] CANON_NAN_REC = 33'h0_E040_0000;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic isNaNRec(input logic [REC_W-1:0] rec);
    return rec[31:29] == 3'b111;
  endfunction
endpackage

// File: rtl/fp_minmax_pick.sv
// fp_minmax_pick: selects the running max/min from a shared comparator result, NaN-aware
module fp_minmax_pick
  import fp_reduce_pkg::*;
(
  input  logic [REC_W-1:0] acc,
  input  logic [REC_W-1:0] elem,
  input  logic             is_max,
  input  logic             lt,
  input  logic             eq,
  input  logic             gt,
  output logic [REC_W-1:0] pick
);
  logic acc_nan, elem_nan, take;
  always_comb begin
    acc_nan  = isNaNRec(acc);
    elem_nan = isNaNRec(elem);
    // equal magnitudes only differ for signed zeros: max prefers +0, min prefers -0
    take = is_max ? (lt | (eq & acc[REC_W-1] & ~elem[REC_W-1]))
                  : (gt | (eq & elem[REC_W-1] & ~acc[REC_W-1]));
    pick = (acc_nan & elem_nan) ? CANON_NAN_REC :
           acc_nan              ? elem :
           elem_nan             ? acc :
           take                 ? elem : acc;
  end
endmodule

// File: rtl/fp_minmax_reduce_seq.sv
// fp_minmax_reduce_seq: element-serial vfredmax/vfredmin sequencer around one shared recoded comparator
module fp_minmax_reduce_seq
  import fp_reduce_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_isMax,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic [REC_W-1:0]  cmd_init,
  input  logic              elem_valid,
  output logic              elem_ready,
  input  logic [REC_W-1:0]  elem_data,
  output logic [REC_W-1:0]  cmp_a,
  output logic [REC_W-1:0]  cmp_b,
  output logic              cmp_signaling,
  input  logic              cmp_lt,
  input  logic              cmp_eq,
  input  logic              cmp_gt,
  input  logic [FLAG_W-1:0] cmp_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REC_W-1:0]  out_data,
  output logic [FLAG_W-1:0] out_flags,
  output logic              busy
);
  state_t state_q, state_d;
  logic [REC_W-1:0] acc_q, acc_d, picked;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic is_max_q, is_max_d;
  fp_minmax_pick u_pick (
    .acc    (acc_q),
    .elem   (elem_data),
    .is_max (is_max_q),
    .lt     (cmp_lt),
    .eq     (cmp_eq),
    .gt     (cmp_gt),
    .pick   (picked)
  );
  always_comb begin
    cmd_ready     = state_q == IDLE;
    elem_ready    = state_q == RUN;
    out_valid     = state_q == DONE;
    busy          = state_q != IDLE;
    cmp_a         = acc_q;
    cmp_b         = elem_data;
    cmp_signaling = 1'b0;
    out_data      = acc_q;
    out_flags     = flags_q;
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    flags_d       = flags_q;
    is_max_d      = is_max_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        is_max_d = cmd_isMax;
        len_d    = cmd_len;
        acc_d    = cmd_init;
        cnt_d    = '0;
        flags_d  = '0;
        state_d  = (cmd_len == '0) ? DONE : RUN;
      end
      RUN: if (elem_valid) begin
        acc_d   = picked;
        flags_d = flags_q | cmp_flags;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == len_q - 1'b1) ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      flags_q  <= '0;
      is_max_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      flags_q  <= flags_d;
      is_max_q <= is_max_d;
    end
  end
endmodule

// File: tb/tb_fp_minmax_reduce_seq.sv
// tb_fp_minmax_reduce_seq: directed vector table plus randomized commands against a real-valued reference
module tb_fp_minmax_reduce_seq;
  localparam int CNT_W = 11;
  localparam logic [32:0] ONE = {1'b0, 9'h100, 23'h0};
  localparam logic [32:0] TWO = {1'b0, 9'h101, 23'h0};
  localparam logic [32:0] THREE = {1'b0, 9'h101, 23'h400000};
  localparam logic [32:0] M5 = {1'b1, 9'h102, 23'h200000};
  localparam logic [32:0] SEVEN = {1'b0, 9'h102, 23'h600000};
  localparam logic [32:0] M25 = {1'b1, 9'h101, 23'h200000};
  localparam logic [32:0] PZ = 33'h0;
  localparam logic [32:0] NZ = {1'b1, 32'h0};
  localparam logic [32:0] QN = 33'h0_E040_0000;
  localparam logic [32:0] QN2 = {1'b1, 9'h1FF, 23'h7FFFFF};
  localparam logic [32:0] SN = {1'b0, 9'h1C0, 23'h000001};
  logic clock = 1'b0, reset = 1'b0;
  logic cmd_valid = 1'b0, cmd_isMax = 1'b0, elem_valid = 1'b0, out_ready = 1'b0;
  logic [CNT_W-1:0] cmd_len = '0;
  logic [32:0] cmd_init = '0, elem_data = '0;
  logic cmd_ready, elem_ready, cmp_signaling, cmp_lt, cmp_eq, cmp_gt, out_valid, busy;
  logic [32:0] cmp_a, cmp_b, out_data;
  logic [4:0] cmp_flags, out_flags, inj = '0;
  int n_cmp = 0, n_bad = 0;
  logic [32:0] eq_q[$];
  logic [4:0] fq_q[$];
  typedef struct {
    bit mx; int len; logic [32:0] init; logic [32:0] e[4]; logic [4:0] f[4];
    logic [32:0] xd; logic [4:0] xf; int hold; int gap;
  } vec_t;
  vec_t tv[12];
  int n_tv = 0;

  fp_minmax_reduce_seq #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_isMax(cmd_isMax), .cmd_len(cmd_len), .cmd_init(cmd_init),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_signaling(cmp_signaling),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_flags(cmp_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic bit is_nan(logic [32:0] r);
    return r[31:29] == 3'b111;
  endfunction
  function automatic bit is_snan(logic [32:0] r);
    return is_nan(r) && !r[22];
  endfunction
  function automatic real rval(logic [32:0] r);
    real m = 1.0 + real'(r[22:0]) / 8388608.0;
    int e = int'(r[31:23]);
    if (r[31:29] == 3'b000) return 0.0;
    return (r[32] ? -m : m) * (2.0 ** real'(e - 256));
  endfunction

  // external quiet comparator, plus optional injected flags to exercise the flag OR
  always_comb begin
    cmp_lt = !is_nan(cmp_a) && !is_nan(cmp_b) && (rval(cmp_a) < rval(cmp_b));
    cmp_eq = !is_nan(cmp_a) && !is_nan(cmp_b) && (rval(cmp_a) == rval(cmp_b));
    cmp_gt = !is_nan(cmp_a) && !is_nan(cmp_b) && (rval(cmp_a) > rval(cmp_b));
    cmp_flags = inj | ((is_snan(cmp_a) || is_snan(cmp_b)) ? 5'h10 : 5'h00);
  end

  function automatic logic [32:0] ref_pick(bit mx, logic [32:0] a, logic [32:0] b);
    real ra = rval(a), rb = rval(b);
    if (is_nan(a) && is_nan(b)) return QN;
    if (is_nan(a)) return b;
    if (is_nan(b)) return a;
    if (ra == rb) return (mx ? (a[32] && !b[32]) : (b[32] && !a[32])) ? b : a;
    return (mx ? (rb > ra) : (rb < ra)) ? b : a;
  endfunction

  task automatic chk(string nm, logic [32:0] act, logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(bit mx, int len, logic [32:0] init);
    int t = 0;
    cmd_valid = 1'b1; cmd_isMax = mx; cmd_len = CNT_W'(len); cmd_init = init;
    @(negedge clock);
    while (!cmd_ready && t < 20) begin @(negedge clock); t++; end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clock); #1 cmd_valid = 1'b0;
  endtask

  task automatic feed(logic [32:0] d, logic [4:0] f, int gap);
    int t = 0;
    repeat (gap) begin @(posedge clock); #1; end
    elem_valid = 1'b1; elem_data = d; inj = f;
    @(negedge clock);
    while (!elem_ready && t < 20) begin @(negedge clock); t++; end
    chk("elem_accept", elem_ready, 1);
    @(posedge clock); #1 elem_valid = 1'b0; inj = '0;
  endtask

  task automatic collect(logic [32:0] xd, logic [4:0] xf, int hold);
    int t = 0;
    @(negedge clock);
    while (!out_valid && t < 20) begin @(negedge clock); t++; end
    chk("out_valid", out_valid, 1);
    repeat (hold) begin
      chk("hold_data", {out_valid, out_data[31:0]}, {1'b1, xd[31:0]});
      @(negedge clock);
    end
    chk("out_data", out_data, xd);
    chk("out_flags", out_flags, xf);
    out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
    chk("idle_after", {busy, cmd_ready, out_valid}, 3'b010);
  endtask

  task automatic run_cmd(bit mx, logic [32:0] init, int gap, int hold, logic [32:0] xd, logic [4:0] xf);
    int n = eq_q.size();
    issue(mx, n, init);
    if (n == 0) chk("latency_len0", out_valid, 1);
    for (int i = 0; i < n; i++) begin
      feed(eq_q[i], fq_q[i], (gap > 0) ? int'($urandom_range(gap)) : 0);
      chk((i == n - 1) ? "latency_last" : "early_valid", out_valid, (i == n - 1) ? 1 : 0);
    end
    collect(xd, xf, hold);
  endtask

  task automatic add(bit mx, int len, logic [32:0] init, logic [32:0] e0, logic [32:0] e1,
                     logic [32:0] e2, logic [32:0] e3, logic [3:0] nx, logic [32:0] xd,
                     logic [4:0] xf, int hold, int gap);
    tv[n_tv].mx = mx; tv[n_tv].len = len; tv[n_tv].init = init;
    tv[n_tv].e[0] = e0; tv[n_tv].e[1] = e1; tv[n_tv].e[2] = e2; tv[n_tv].e[3] = e3;
    for (int k = 0; k < 4; k++) tv[n_tv].f[k] = nx[k] ? 5'h01 : 5'h00;
    tv[n_tv].xd = xd; tv[n_tv].xf = xf; tv[n_tv].hold = hold; tv[n_tv].gap = gap;
    n_tv++;
  endtask

  initial begin
    add(1, 3, ONE, TWO, M5, THREE, PZ, 4'h0, THREE, 5'h00, 0, 0);
    add(0, 2, PZ, NZ, PZ, PZ, PZ, 4'h0, NZ, 5'h00, 0, 0);
    add(1, 2, PZ, NZ, PZ, PZ, PZ, 4'h0, PZ, 5'h00, 0, 0);
    add(1, 2, QN2, QN, SEVEN, PZ, PZ, 4'h0, SEVEN, 5'h00, 0, 0);
    add(1, 2, QN2, QN2, QN, PZ, PZ, 4'h0, QN, 5'h00, 0, 0);
    add(0, 1, ONE, SN, PZ, PZ, PZ, 4'h0, ONE, 5'h10, 0, 0);
    add(0, 0, M25, PZ, PZ, PZ, PZ, 4'h0, M25, 5'h00, 5, 0);
    add(1, 0, SN, PZ, PZ, PZ, PZ, 4'h0, SN, 5'h00, 0, 0);
    add(0, 4, THREE, TWO, M5, NZ, SEVEN, 4'h4, M5, 5'h01, 2, 2);
    #12;
    chk("rst_outs", {cmd_ready, elem_ready, out_valid, busy}, 4'b1000);
    chk("rst_data", out_data, 33'h0);
    chk("rst_flags", out_flags, 5'h0);
    @(posedge clock); #1 reset = 1'b1;
    for (int v = 0; v < n_tv; v++) begin
      eq_q.delete(); fq_q.delete();
      for (int k = 0; k < tv[v].len; k++) begin eq_q.push_back(tv[v].e[k]); fq_q.push_back(tv[v].f[k]); end
      run_cmd(tv[v].mx, tv[v].init, tv[v].gap, tv[v].hold, tv[v].xd, tv[v].xf);
    end
    // abort a command mid-stream, then check a fresh one runs clean
    issue(1, 5, ONE);
    feed(SEVEN, 5'h01, 1);
    feed(TWO, 5'h00, 2);
    #2 reset = 1'b0;
    #1 chk("rst_mid", {busy, cmd_ready, elem_ready, out_valid}, 4'b0100);
    chk("rst_mid_acc", out_data, 33'h0);
    @(posedge clock); #1 reset = 1'b1;
    eq_q.delete(); fq_q.delete();
    eq_q.push_back(ONE); fq_q.push_back(5'h00);
    run_cmd(1, M25, 0, 0, ONE, 5'h00);
    for (int r = 0; r < 40; r++) begin
      logic [32:0] pool[11] = '{ONE, TWO, THREE, M5, SEVEN, M25, PZ, NZ, QN, QN2, SN};
      bit mx = 1'($urandom_range(1));
      int len = $urandom_range(6);
      logic [32:0] init = pool[$urandom_range(10)];
      logic [32:0] acc = init;
      logic [4:0] fl = '0;
      eq_q.delete(); fq_q.delete();
      for (int k = 0; k < len; k++) begin
        logic [32:0] e = pool[$urandom_range(10)];
        logic [4:0] f = ($urandom_range(7) == 0) ? 5'h01 : 5'h00;
        eq_q.push_back(e); fq_q.push_back(f);
        fl |= f | ((is_snan(acc) || is_snan(e)) ? 5'h10 : 5'h00);
        acc = ref_pick(mx, acc, e);
      end
      run_cmd(mx, init, 2, $urandom_range(2), acc, fl);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
